// File: rtl/reflet_boot_loader.sv
// Serial program loader: holds the CPU in reset, receives a framed image over the
// UART byte stream, writes it word by word into instruction RAM, then releases the CPU.
module reflet_boot_loader #(
  parameter int wordsize     = 16,
  parameter int addr_size    = 16,
  parameter int base_addr    = 0,
  parameter int max_len      = 256,
  parameter int boot_wait    = 1000000,
  parameter int byte_timeout = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [addr_size-1:0] mem_addr,
  output logic [wordsize-1:0]  mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_reset,
  output logic                 loading,
  output logic                 error,
  output logic                 done
);

  localparam int NB     = wordsize / 8;
  localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int WAIT_W = $clog2(boot_wait + 1);
  localparam int GAP_W  = $clog2(byte_timeout + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(boot_wait - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(byte_timeout - 1);
  localparam logic [addr_size-1:0] BASE      = addr_size'(base_addr);
  localparam logic [15:0]          MAX_LEN   = 16'(max_len);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NB - 1);
  localparam logic [7:0]           SYNC      = 8'hA5;

  typedef enum logic [2:0] {
    S_WAIT, S_LEN0, S_LEN1, S_DATA, S_CHK, S_ERR, S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           sum_q, sum_d;
  logic [wordsize-1:0]  word_q, word_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic [wordsize-1:0]  data_q, data_d;
  logic                 we_q, we_d;
  logic                 cpu_reset_q, loading_q, error_q, done_q;

  logic                 in_frame;
  logic [15:0]          len_full;
  logic [wordsize-1:0]  word_nxt;
  logic                 last_byte;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gap_d     = '0;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    word_d    = word_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    in_frame  = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
    len_full  = {rx_data, len_q[7:0]};
    word_nxt  = word_q | (wordsize'(rx_data) << (8 * idx_q));
    last_byte = (cnt_q == len_q - 16'd1);

    // Address advances as the write strobe retires, so it is stable during the pulse.
    if (we_q) addr_d = addr_q + addr_size'(1);
    if (in_frame && !rx_valid) gap_d = gap_q + GAP_W'(1);

    case (state_q)
      S_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (rx_valid && rx_data == SYNC) begin
          state_d = S_LEN0;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_RUN;
        end
      end
      S_LEN0: if (rx_valid) begin
        len_d[7:0] = rx_data;
        state_d    = S_LEN1;
      end
      S_LEN1: if (rx_valid) begin
        len_d = len_full;
        if (len_full > MAX_LEN)   state_d = S_ERR;
        else if (len_full == '0)  state_d = S_CHK;
        else                      state_d = S_DATA;
      end
      S_DATA: if (rx_valid) begin
        sum_d = sum_q + rx_data;
        cnt_d = cnt_q + 16'd1;
        if (idx_q == IDX_LAST || last_byte) begin
          data_d = word_nxt;
          we_d   = 1'b1;
          word_d = '0;
          idx_d  = '0;
        end else begin
          word_d = word_nxt;
          idx_d  = idx_q + IDX_W'(1);
        end
        if (last_byte) state_d = S_CHK;
      end
      S_CHK: if (rx_valid) begin
        state_d = (rx_data == sum_q) ? S_RUN : S_ERR;
      end
      S_ERR: begin
        state_d = S_WAIT;
        wait_d  = '0;
        sum_d   = '0;
        cnt_d   = '0;
        word_d  = '0;
        idx_d   = '0;
        addr_d  = BASE;
      end
      default: ;
    endcase

    if (in_frame && !rx_valid && gap_q == GAP_LAST) state_d = S_ERR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_WAIT;
      wait_q      <= '0;
      gap_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      addr_q      <= BASE;
      data_q      <= '0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b0;
      loading_q   <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      gap_q       <= gap_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      cpu_reset_q <= (state_q == S_RUN);
      loading_q   <= state_d inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
      error_q     <= error_q | (state_d == S_ERR);
      done_q      <= (state_d == S_RUN);
    end
  end

  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_write_en = we_q;
  assign cpu_reset    = cpu_reset_q;
  assign loading      = loading_q;
  assign error        = error_q;
  assign done         = done_q;

endmodule

// File: tb/tb_reflet_boot_loader.sv
// Directed bench for reflet_boot_loader: a 16-bit instance with a wrapping 8-bit
// address space and a 32-bit instance, both driven from one linear sequence.
module tb_reflet_boot_loader;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rxd16 = '0, rxd32 = '0;
  logic        rxv16 = 1'b0, rxv32 = 1'b0;
  logic [7:0]  a16;
  logic [15:0] d16;
  logic [15:0] a32;
  logic [31:0] d32;
  logic        we16, cr16, ld16, er16, dn16;
  logic        we32, cr32, ld32, er32, dn32;
  logic [47:0] wq16[$], wq32[$];
  int          n_tests = 0, n_fail = 0;
  bq_t         bq;

  always #5 clk = ~clk;

  reflet_boot_loader #(.wordsize(16), .addr_size(8), .base_addr('hFE), .max_len(8),
                       .boot_wait(200), .byte_timeout(20)) dut16 (
    .clk(clk), .reset(reset), .rx_data(rxd16), .rx_valid(rxv16),
    .mem_addr(a16), .mem_data(d16), .mem_write_en(we16), .cpu_reset(cr16),
    .loading(ld16), .error(er16), .done(dn16));

  reflet_boot_loader #(.wordsize(32), .addr_size(16), .base_addr(0), .max_len(16),
                       .boot_wait(300), .byte_timeout(20)) dut32 (
    .clk(clk), .reset(reset), .rx_data(rxd32), .rx_valid(rxv32),
    .mem_addr(a32), .mem_data(d32), .mem_write_en(we32), .cpu_reset(cr32),
    .loading(ld32), .error(er32), .done(dn32));

  always @(negedge clk) begin
    if (we16) wq16.push_back({8'h00, a16, 16'h0000, d16});
    if (we32) wq32.push_back({a32, d32});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel32, input logic [7:0] b);
    @(negedge clk);
    if (sel32) begin rxd32 = b; rxv32 = 1'b1; end
    else       begin rxd16 = b; rxv16 = 1'b1; end
    @(negedge clk);
    rxv16 = 1'b0;
    rxv32 = 1'b0;
  endtask

  task automatic send_seq(input bit sel32, input bq_t s);
    foreach (s[i]) send(sel32, s[i]);
  endtask

  task automatic expect_write(input bit sel32, input string tag,
                              input logic [15:0] ea, input logic [31:0] ed);
    logic [47:0] e;
    int sz;
    sz = sel32 ? wq32.size() : wq16.size();
    chk({tag, " present"}, 64'(sz > 0), 64'd1);
    if (sz > 0) begin
      e = sel32 ? wq32.pop_front() : wq16.pop_front();
      chk({tag, " addr"}, 64'(e[47:32]), 64'(ea));
      chk({tag, " data"}, 64'(e[31:0]), 64'(ed));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rxv16 = 1'b0;
    rxv32 = 1'b0;
    repeat (3) @(negedge clk);
    wq16.delete();
    wq32.delete();
    reset = 1'b1;
  endtask

  initial begin
    // T4: boot window expiry with no input
    do_reset();
    chk("rst cpu_reset", 64'(cr16), 64'd0);
    chk("rst mem_addr", 64'(a16), 64'hFE);
    chk("rst mem_data", 64'(d16), 64'd0);
    chk("rst we", 64'(we16), 64'd0);
    chk("rst loading", 64'(ld16), 64'd0);
    chk("rst error", 64'(er16), 64'd0);
    chk("rst done", 64'(dn16), 64'd0);
    repeat (199) @(negedge clk);
    chk("t4 done before expiry", 64'(dn16), 64'd0);
    @(negedge clk);
    chk("t4 done at expiry", 64'(dn16), 64'd1);
    chk("t4 cpu_reset at expiry", 64'(cr16), 64'd0);
    @(negedge clk);
    chk("t4 cpu_reset after", 64'(cr16), 64'd1);
    chk("t4 no writes", 64'(wq16.size()), 64'd0);

    // T1: 16-bit frame, non-sync byte ignored, address wraps after 0xFF
    do_reset();
    send(0, 8'h55);
    chk("t1 junk ignored", 64'(ld16), 64'd0);
    send(0, 8'hA5);
    chk("t1 loading", 64'(ld16), 64'd1);
    bq = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_seq(0, bq);
    chk("t1 done", 64'(dn16), 64'd1);
    chk("t1 cpu_reset held", 64'(cr16), 64'd0);
    chk("t1 loading cleared", 64'(ld16), 64'd0);
    chk("t1 addr wrapped", 64'(a16), 64'h00);
    @(negedge clk);
    chk("t1 cpu_reset", 64'(cr16), 64'd1);
    chk("t1 error", 64'(er16), 64'd0);
    expect_write(0, "t1 w0", 16'h00FE, 32'h2211);
    expect_write(0, "t1 w1", 16'h00FF, 32'h4433);

    // T3: bad checksum, then a good frame
    do_reset();
    bq = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h00};
    send_seq(0, bq);
    chk("t3 error", 64'(er16), 64'd1);
    chk("t3 cpu_reset", 64'(cr16), 64'd0);
    @(negedge clk);
    chk("t3 addr rewound", 64'(a16), 64'hFE);
    chk("t3 loading", 64'(ld16), 64'd0);
    chk("t3 not done", 64'(dn16), 64'd0);
    expect_write(0, "t3 w0", 16'h00FE, 32'h3412);
    bq = '{8'hA5, 8'h02, 8'h00, 8'hAB, 8'hCD, 8'h78};
    send_seq(0, bq);
    chk("t3 reload done", 64'(dn16), 64'd1);
    chk("t3 error sticky", 64'(er16), 64'd1);
    expect_write(0, "t3 w1", 16'h00FE, 32'hCDAB);

    // T5: inter-byte timeout, then oversize length
    do_reset();
    bq = '{8'hA5, 8'h03, 8'h00};
    send_seq(0, bq);
    repeat (19) @(negedge clk);
    chk("t5 no timeout yet", 64'(er16), 64'd0);
    @(negedge clk);
    chk("t5 timeout error", 64'(er16), 64'd1);
    chk("t5 loading", 64'(ld16), 64'd0);
    do_reset();
    bq = '{8'hA5, 8'h09, 8'h00};
    send_seq(0, bq);
    chk("t5 oversize error", 64'(er16), 64'd1);
    repeat (4) @(negedge clk);
    chk("t5 oversize no writes", 64'(wq16.size()), 64'd0);

    // T6: async reset mid-DATA with a write about to issue
    do_reset();
    bq = '{8'hA5, 8'h06, 8'h00, 8'h01, 8'h02, 8'h03};
    send_seq(0, bq);
    expect_write(0, "t6 w0", 16'h00FE, 32'h0201);
    @(negedge clk);
    rxd16 = 8'h04;
    rxv16 = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6 we", 64'(we16), 64'd0);
    chk("t6 cpu_reset", 64'(cr16), 64'd0);
    chk("t6 addr", 64'(a16), 64'hFE);
    chk("t6 data", 64'(d16), 64'd0);
    chk("t6 loading", 64'(ld16), 64'd0);
    rxv16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6 write lost", 64'(wq16.size()), 64'd0);
    reset = 1'b1;
    bq = '{8'hA5, 8'h06, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    send_seq(0, bq);
    chk("t6 done", 64'(dn16), 64'd1);
    expect_write(0, "t6 r0", 16'h00FE, 32'h0201);
    expect_write(0, "t6 r1", 16'h00FF, 32'h0403);
    expect_write(0, "t6 r2", 16'h0000, 32'h0605);

    // T2: 32-bit words with a partial last word
    do_reset();
    bq = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F};
    send_seq(1, bq);
    chk("t2 done", 64'(dn32), 64'd1);
    @(negedge clk);
    chk("t2 cpu_reset", 64'(cr32), 64'd1);
    chk("t2 error", 64'(er32), 64'd0);
    expect_write(1, "t2 w0", 16'h0000, 32'h04030201);
    expect_write(1, "t2 w1", 16'h0001, 32'h00000005);

    // Zero-length frame goes straight to checksum
    do_reset();
    bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq(1, bq);
    chk("len0 done", 64'(dn32), 64'd1);
    chk("len0 error", 64'(er32), 64'd0);
    chk("len0 no writes", 64'(wq32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
